// File: rtl/delay_ms_timer_if.sv
// delay_ms_timer_if: control/status bundle of the millisecond delay timer.
// master drives START/N and watches status; slave is the timer itself.
interface delay_ms_timer_if #(
    parameter int NBIT = 14
);
    logic            START;
    logic [NBIT-1:0] N;
    logic            BUSY;
    logic            TIME_OUT;
    logic [NBIT-1:0] MS_LEFT;

    modport master (
        output START, N,
        input  BUSY, TIME_OUT, MS_LEFT
    );

    modport slave (
        input  START, N,
        output BUSY, TIME_OUT, MS_LEFT
    );
endinterface

// File: rtl/delay_ms_timer.sv
// delay_ms_timer: one-shot delay of N ms, counted on rising edges of a
// 1 kHz square wave already synchronous to CLOCK_IN.
// Ports:
//   CLOCK_IN  - 50 MHz system clock, rising edge
//   RESET_N   - synchronous active-low reset
//   TICK_IN   - 1 kHz square wave from the tick divider
//   tmr.START - start/retrigger, tmr.N - delay in ms (sampled with START)
//   tmr.BUSY  - counting, tmr.TIME_OUT - one-cycle expiry pulse
//   tmr.MS_LEFT - remaining milliseconds
module delay_ms_timer #(
    parameter int NBIT = 14
) (
    input  logic                  CLOCK_IN,
    input  logic                  RESET_N,
    input  logic                  TICK_IN,
    delay_ms_timer_if.slave       tmr
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [NBIT-1:0] count_q, count_d;
    logic            tick_q, tick_d;
    logic            ms_en;

    always_ff @(posedge CLOCK_IN) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            count_q <= '0;
            // Held high so a tick already high at release is not an edge.
            tick_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        tick_d  = TICK_IN;
        ms_en   = TICK_IN & ~tick_q;
        state_d = state_q;
        count_d = count_q;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE falls back to IDLE but accepts a start like IDLE.
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (tmr.START) begin
                    count_d = tmr.N;
                    state_d = (tmr.N != '0) ? COUNT : DONE;
                end
            end
            COUNT: begin
                // Reload wins over a coincident millisecond edge.
                if (tmr.START) begin
                    count_d = tmr.N;
                    if (tmr.N == '0) begin
                        state_d = DONE;
                    end
                end else if (ms_en) begin
                    if (count_q == NBIT'(1)) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q - NBIT'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign tmr.BUSY     = (state_q == COUNT);
    assign tmr.TIME_OUT = (state_q == DONE);
    assign tmr.MS_LEFT  = count_q;

endmodule
